// File: rtl/atm_disp_pkg.sv
// Shared types and constants for the ATM cash dispenser: denominations,
// cassette indices, completion codes and the controller state encoding.
package atm_disp_pkg;

  localparam logic [31:0] DENOM_200 = 32'd200;
  localparam logic [31:0] DENOM_100 = 32'd100;
  localparam logic [31:0] DENOM_50  = 32'd50;

  localparam logic [1:0] CAS_200 = 2'd0;
  localparam logic [1:0] CAS_100 = 2'd1;
  localparam logic [1:0] CAS_50  = 2'd2;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_AMOUNT  = 2'b01;
  localparam logic [1:0] ERR_FULFIL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_PLAN     = 3'd2,
    ST_DISPENSE = 3'd3,
    ST_PRESENT  = 3'd4,
    ST_RETRACT  = 3'd5,
    ST_DONE     = 3'd6
  } disp_state_t;

  function automatic logic [31:0] denom_of(input logic [1:0] idx);
    case (idx)
      CAS_200: return DENOM_200;
      CAS_100: return DENOM_100;
      CAS_50:  return DENOM_50;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/atm_disp_planner.sv
// Amount validation and greedy note planning (200/100/50), one step per cycle.
// Holds the per-cassette plan counts, which are consumed as notes are fed.
module atm_disp_planner
  import atm_disp_pkg::*;
#(
  parameter int AMT_W     = 32,
  parameter int CNT_W     = 10,
  parameter int MAX_NOTES = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [AMT_W-1:0] amount,
  input  logic             check,
  input  logic             step,
  input  logic             note_fed,
  input  logic [1:0]       fed_sel,
  input  logic [CNT_W-1:0] cnt0,
  input  logic [CNT_W-1:0] cnt1,
  input  logic [CNT_W-1:0] cnt2,
  output logic             amount_bad,
  output logic             plan_last,
  output logic             plan_ok,
  output logic [CNT_W-1:0] p0,
  output logic [CNT_W-1:0] p1,
  output logic [CNT_W-1:0] p2
);

  localparam int TOT_W = $clog2(MAX_NOTES + 1);

  logic [AMT_W-1:0] rem;
  logic [CNT_W-1:0] plan [3];
  logic [TOT_W-1:0] total;
  logic [1:0]       d;
  logic [AMT_W-1:0] denom_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] plan_d;
  logic             take;

  // Greedy decision for the current denomination.
  always_comb begin
    denom_d = AMT_W'(denom_of(d));
    case (d)
      CAS_200: begin cnt_d = cnt0; plan_d = plan[0]; end
      CAS_100: begin cnt_d = cnt1; plan_d = plan[1]; end
      CAS_50:  begin cnt_d = cnt2; plan_d = plan[2]; end
      default: begin cnt_d = '0;   plan_d = '0;      end
    endcase
    take = (rem >= denom_d) && (plan_d < cnt_d) && (total < TOT_W'(MAX_NOTES));
  end

  assign amount_bad = (rem == '0) || ((rem % AMT_W'(DENOM_50)) != '0);
  assign plan_last  = step && (d == CAS_50) && !take;
  assign plan_ok    = (rem == '0);
  assign p0 = plan[0];
  assign p1 = plan[1];
  assign p2 = plan[2];

  // Remainder, plan counts, note total and denomination pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem   <= '0;
      total <= '0;
      d     <= CAS_200;
      for (int i = 0; i < 3; i++) plan[i] <= '0;
    end else if (load) begin
      rem <= amount;
    end else if (check && !amount_bad) begin
      total <= '0;
      d     <= CAS_200;
      for (int i = 0; i < 3; i++) plan[i] <= '0;
    end else if (step) begin
      if (take) begin
        rem   <= rem - denom_d;
        total <= total + TOT_W'(1);
        for (int i = 0; i < 3; i++) begin
          if (d == 2'(i)) plan[i] <= plan[i] + CNT_W'(1);
        end
      end else if (d != CAS_50) begin
        d <= d + 2'd1;
      end else begin
        d <= d;
      end
    end else if (note_fed) begin
      for (int i = 0; i < 3; i++) begin
        if (fed_sel == 2'(i)) plan[i] <= plan[i] - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/atm_cash_dispenser.sv
// ATM cash dispenser: validates and plans a withdrawal, feeds notes, presents cash.
// Optional ATM_DISP_AUDIT_EN adds audit_total / audit_retracts counters.
module atm_cash_dispenser
  import atm_disp_pkg::*;
#(
  parameter int AMT_W        = 32,
  parameter int CNT_W        = 10,
  parameter int INIT_C200    = 20,
  parameter int INIT_C100    = 20,
  parameter int INIT_C50     = 20,
  parameter int MAX_NOTES    = 40,
  parameter int TAKE_TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             refill,
  output logic             disp_note_valid,
  output logic [1:0]       disp_note_sel,
  input  logic             disp_note_ack,
  input  logic             cash_taken,
  output logic             present_open,
  output logic             done_valid,
  output logic [1:0]       done_err,
  output logic [CNT_W-1:0] cnt200,
  output logic [CNT_W-1:0] cnt100,
  output logic [CNT_W-1:0] cnt50
`ifdef ATM_DISP_AUDIT_EN
  ,
  output logic [AMT_W-1:0] audit_total,
  output logic [7:0]       audit_retracts
`endif
);

  localparam int TMR_W = $clog2(TAKE_TIMEOUT + 1);

  disp_state_t      state, state_n;
  logic [CNT_W-1:0] cnt [3];
  logic [TMR_W-1:0] timer;
  logic             valid_n;
  logic [1:0]       sel_n;
  logic [1:0]       done_err_n;
  logic             accept, note_fed, refill_ok;
  logic             amount_bad, plan_last, plan_ok;
  logic [CNT_W-1:0] p0, p1, p2;

  assign accept    = req_valid && req_ready;
  assign note_fed  = (state == ST_DISPENSE) && disp_note_valid && disp_note_ack;
  assign refill_ok = (state == ST_IDLE) && refill;
  assign cnt200 = cnt[0];
  assign cnt100 = cnt[1];
  assign cnt50  = cnt[2];

  atm_disp_planner #(
    .AMT_W     (AMT_W),
    .CNT_W     (CNT_W),
    .MAX_NOTES (MAX_NOTES)
  ) u_planner (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .amount     (req_amount),
    .check      (state == ST_CHECK),
    .step       (state == ST_PLAN),
    .note_fed   (note_fed),
    .fed_sel    (disp_note_sel),
    .cnt0       (cnt[0]),
    .cnt1       (cnt[1]),
    .cnt2       (cnt[2]),
    .amount_bad (amount_bad),
    .plan_last  (plan_last),
    .plan_ok    (plan_ok),
    .p0         (p0),
    .p1         (p1),
    .p2         (p2)
  );

  // Next state and next values of the registered outputs.
  always_comb begin
    state_n    = state;
    valid_n    = 1'b0;
    sel_n      = disp_note_sel;
    done_err_n = done_err;
    case (state)
      ST_IDLE: begin
        if (accept) state_n = ST_CHECK;
        else        state_n = ST_IDLE;
      end
      ST_CHECK: begin
        if (amount_bad) begin
          state_n    = ST_DONE;
          done_err_n = ERR_AMOUNT;
        end else begin
          state_n = ST_PLAN;
        end
      end
      ST_PLAN: begin
        if (plan_last) begin
          if (plan_ok) begin
            state_n = ST_DISPENSE;
          end else begin
            state_n    = ST_DONE;
            done_err_n = ERR_FULFIL;
          end
        end else begin
          state_n = ST_PLAN;
        end
      end
      ST_DISPENSE: begin
        // Valid drops for one cycle after each ack so the plan counts settle.
        if (note_fed) begin
          valid_n = 1'b0;
        end else if (disp_note_valid) begin
          valid_n = 1'b1;
        end else if (p0 != '0) begin
          valid_n = 1'b1;
          sel_n   = CAS_200;
        end else if (p1 != '0) begin
          valid_n = 1'b1;
          sel_n   = CAS_100;
        end else if (p2 != '0) begin
          valid_n = 1'b1;
          sel_n   = CAS_50;
        end else begin
          state_n = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (cash_taken) begin
          state_n    = ST_DONE;
          done_err_n = ERR_OK;
        end else if (timer == TMR_W'(TAKE_TIMEOUT - 1)) begin
          state_n = ST_RETRACT;
        end else begin
          state_n = ST_PRESENT;
        end
      end
      ST_RETRACT: begin
        state_n    = ST_DONE;
        done_err_n = ERR_TIMEOUT;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      req_ready       <= 1'b1;
      disp_note_valid <= 1'b0;
      disp_note_sel   <= CAS_200;
      present_open    <= 1'b0;
      done_valid      <= 1'b0;
      done_err        <= ERR_OK;
    end else begin
      state           <= state_n;
      req_ready       <= (state_n == ST_IDLE);
      disp_note_valid <= valid_n;
      disp_note_sel   <= sel_n;
      present_open    <= (state_n == ST_PRESENT);
      done_valid      <= (state_n == ST_DONE);
      done_err        <= done_err_n;
    end
  end

  // Presenter timer, restarted on every entry to PRESENT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (state != ST_PRESENT) begin
      timer <= '0;
    end else begin
      timer <= timer + TMR_W'(1);
    end
  end

  // Cassette counts: reload on refill in IDLE, decrement per fed note.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || refill_ok) begin
      cnt[0] <= CNT_W'(INIT_C200);
      cnt[1] <= CNT_W'(INIT_C100);
      cnt[2] <= CNT_W'(INIT_C50);
    end else if (note_fed) begin
      for (int i = 0; i < 3; i++) begin
        if (disp_note_sel == 2'(i)) cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

`ifdef ATM_DISP_AUDIT_EN
  // Audit counters survive refill; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audit_total    <= '0;
      audit_retracts <= 8'd0;
    end else begin
      if (note_fed) audit_total <= audit_total + AMT_W'(denom_of(disp_note_sel));
      else          audit_total <= audit_total;
      if ((state == ST_RETRACT) && (audit_retracts != 8'hFF))
        audit_retracts <= audit_retracts + 8'd1;
      else
        audit_retracts <= audit_retracts;
    end
  end
`endif

endmodule
